// File: rtl/lvds_ser_pkg.sv
// Shared definitions for the LVDS serializer sequencing controller:
// FSM state encodings, PRBS7 constants and counter-width helpers.
package lvds_ser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RESET  = 3'd1,
    SETTLE = 3'd2,
    TRAIN  = 3'd3,
    RUN    = 3'd4
  } ser_state_e;

  // PRBS7 polynomial x^7 + x^6 + 1: feedback taps are state bits 6 and 5
  // of a left-shifting register whose bit 0 holds the newest bit.
  localparam logic [6:0] PRBS7_SEED   = 7'h7F;
  localparam int         PRBS7_TAP_HI = 6;
  localparam int         PRBS7_TAP_LO = 5;

  // Bits needed to hold values 0..max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lvds_prbs7_gen.sv
// PRBS7 word generator producing DEV_W bits per cycle, bit 0 first in time.
// load presents the word generated from the seed in the same cycle and
// stores the advanced state; advance steps from the stored state.
module lvds_prbs7_gen
  import lvds_ser_pkg::*;
#(
  parameter int DEV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [DEV_W-1:0] data
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_next;

  // Unroll DEV_W LFSR steps from either the seed or the stored state.
  always_comb begin
    logic fb;
    lfsr_next = load ? PRBS7_SEED : lfsr_q;
    data      = '0;
    for (int k = 0; k < DEV_W; k++) begin
      fb        = lfsr_next[PRBS7_TAP_HI] ^ lfsr_next[PRBS7_TAP_LO];
      data[k]   = fb;
      lfsr_next = {lfsr_next[5:0], fb};
    end
  end

  // LFSR state register; holds when neither loading nor advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= PRBS7_SEED;
    end else if (load || advance) begin
      lfsr_q <= lfsr_next;
    end
  end

endmodule

// File: rtl/lvds_ser_ctrl.sv
// Sequencing controller for a 4:1 DDR LVDS output serializer.
// Brings the serializer out of reset, lets it settle, sends a training
// burst and then streams user words. Optional macro LVDS_SER_CTRL_PRBS_EN
// replaces the constant training word with a PRBS7 sequence.
//
// Handshake: s_ready depends only on state, enable and retrain (never on
// s_valid); a word transfers on s_valid & s_ready and appears on ser_data
// the following cycle.
module lvds_ser_ctrl
  import lvds_ser_pkg::*;
#(
  parameter int               DEV_W         = 4,
  parameter int               RST_CYCLES    = 4,
  parameter int               SETTLE_CYCLES = 8,
  parameter int               TRAIN_WORDS   = 16,
  parameter logic [DEV_W-1:0] TRAIN_PAT     = 4'b1010,
  parameter logic [DEV_W-1:0] IDLE_PAT      = 4'b0000,
  parameter int               UCNT_W        = 16
) (
  input  logic              clk_div_in,
  input  logic              io_reset,
  input  logic              enable,
  input  logic              retrain,
  input  logic [DEV_W-1:0]  s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DEV_W-1:0]  ser_data,
  output logic              ser_rst,
  output logic              link_up,
  output logic [UCNT_W-1:0] underflow_cnt,
  output logic [2:0]        state_o
);

  localparam int PH_MAX = max3(RST_CYCLES, SETTLE_CYCLES, TRAIN_WORDS);
  localparam int PH_W   = cnt_width(PH_MAX);

  localparam logic [PH_W-1:0] RST_LAST    = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0] TRAIN_LAST  = PH_W'(TRAIN_WORDS - 1);

  ser_state_e        state;
  ser_state_e        next_state;
  logic [PH_W-1:0]   phase;
  logic              state_entry;
  logic              ser_rst_d;
  logic              link_up_d;
  logic [DEV_W-1:0]  ser_data_d;
  logic [DEV_W-1:0]  train_word;

  assign state_o     = state;
  assign state_entry = (next_state != state);

`ifdef LVDS_SER_CTRL_PRBS_EN
  logic prbs_load;
  logic prbs_adv;

  // Reseed on every TRAIN entry so each burst starts from the same word.
  assign prbs_load = (next_state == TRAIN) && (state != TRAIN);
  assign prbs_adv  = (next_state == TRAIN) && (state == TRAIN);

  lvds_prbs7_gen #(
    .DEV_W (DEV_W)
  ) u_prbs (
    .clk     (clk_div_in),
    .rst     (io_reset),
    .load    (prbs_load),
    .advance (prbs_adv),
    .data    (train_word)
  );
`else
  assign train_word = TRAIN_PAT;
`endif

  // Accept user data only in RUN when the link is not about to leave it.
  always_comb begin
    s_ready = (state == RUN) && enable && !retrain;
  end

  // Next-state selection: enable low beats retrain; retrain ignored in
  // IDLE and RESET.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:   next_state = RESET;
        RESET:  if (phase == RST_LAST) next_state = SETTLE;
        SETTLE: begin
          if (retrain)                    next_state = RESET;
          else if (phase == SETTLE_LAST)  next_state = TRAIN;
        end
        TRAIN: begin
          if (retrain)                    next_state = RESET;
          else if (phase == TRAIN_LAST)   next_state = RUN;
        end
        RUN:    if (retrain) next_state = RESET;
        default: next_state = IDLE;
      endcase
    end
  end

  // Output words follow the state being entered so they line up with it.
  always_comb begin
    ser_rst_d  = 1'b1;
    link_up_d  = 1'b0;
    ser_data_d = IDLE_PAT;
    case (next_state)
      SETTLE: ser_rst_d = 1'b0;
      TRAIN: begin
        ser_rst_d  = 1'b0;
        ser_data_d = train_word;
      end
      RUN: begin
        ser_rst_d = 1'b0;
        link_up_d = 1'b1;
        if (s_ready && s_valid) ser_data_d = s_data;
      end
      default: ;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_div_in) begin
    if (io_reset) begin
      state    <= IDLE;
      ser_rst  <= 1'b1;
      link_up  <= 1'b0;
      ser_data <= IDLE_PAT;
    end else begin
      state    <= next_state;
      ser_rst  <= ser_rst_d;
      link_up  <= link_up_d;
      ser_data <= ser_data_d;
    end
  end

  // Phase counter restarts on every state entry; each timed state exits at
  // its last count, so the counter never wraps.
  always_ff @(posedge clk_div_in) begin
    if (io_reset || state_entry) begin
      phase <= '0;
    end else if (state == RESET || state == SETTLE || state == TRAIN) begin
      phase <= phase + 1'b1;
    end
  end

  // Underflow counter: cleared on RESET entry, counts RUN cycles without
  // a user word and sticks at all-ones.
  always_ff @(posedge clk_div_in) begin
    if (io_reset) begin
      underflow_cnt <= '0;
    end else if (next_state == RESET && state != RESET) begin
      underflow_cnt <= '0;
    end else if (state == RUN && !s_valid && underflow_cnt != {UCNT_W{1'b1}}) begin
      underflow_cnt <= underflow_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lvds_ser_ctrl.sv
// Bench for lvds_ser_ctrl. A second instance with a 4-bit underflow
// counter shares the stimulus to exercise counter saturation.
module tb_lvds_ser_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RESET  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_TRAIN  = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;

  typedef struct packed {
    logic [2:0]  st;
    logic        rst;
    logic [3:0]  data;
    logic        link;
    logic        rdy;
    logic        chk_u;
    logic [15:0] u;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic        clk_div_in = 1'b0;
  logic        io_reset   = 1'b1;
  logic        enable     = 1'b0;
  logic        retrain    = 1'b0;
  logic [3:0]  s_data     = 4'h0;
  logic        s_valid    = 1'b0;

  logic        s_ready;
  logic [3:0]  ser_data;
  logic        ser_rst;
  logic        link_up;
  logic [15:0] underflow_cnt;
  logic [2:0]  state_o;

  logic        sat_ready;
  logic [3:0]  sat_data;
  logic        sat_rst;
  logic        sat_link;
  logic [3:0]  sat_ucnt;
  logic [2:0]  sat_state;

  // ---------------- clock ----------------
  always #5 clk_div_in = ~clk_div_in;

  lvds_ser_ctrl dut (
    .clk_div_in    (clk_div_in),
    .io_reset      (io_reset),
    .enable        (enable),
    .retrain       (retrain),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .ser_data      (ser_data),
    .ser_rst       (ser_rst),
    .link_up       (link_up),
    .underflow_cnt (underflow_cnt),
    .state_o       (state_o)
  );

  lvds_ser_ctrl #(.UCNT_W(4)) dut_sat (
    .clk_div_in    (clk_div_in),
    .io_reset      (io_reset),
    .enable        (enable),
    .retrain       (retrain),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (sat_ready),
    .ser_data      (sat_data),
    .ser_rst       (sat_rst),
    .link_up       (sat_link),
    .underflow_cnt (sat_ucnt),
    .state_o       (sat_state)
  );

  // Expected training word i: constant pattern, or the PRBS7 reference
  // built from the recurrence b[n] = b[n-7] ^ b[n-6] with an all-ones seed.
  function automatic logic [3:0] train_word(input int i);
`ifdef LVDS_SER_CTRL_PRBS_EN
    logic [135:0] b;
    logic [3:0]   w;
    b = '0;
    for (int n = 0; n < 7; n++) b[n] = 1'b1;
    for (int n = 7; n < 136; n++) b[n] = b[n-7] ^ b[n-6];
    for (int j = 0; j < 4; j++) w[j] = b[7 + 4*i + j];
    return w;
`else
    return (i >= 0) ? 4'b1010 : 4'b1010;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive inputs at the falling edge and queue what the monitor
  // should see right after (registered outputs from the last rising edge,
  // s_ready for the inputs just applied).
  task automatic step(input logic rs, input logic en, input logic rt,
                      input logic sv, input logic [3:0] sd,
                      input logic [2:0] st, input logic r, input logic [3:0] d,
                      input logic lk, input logic rdy,
                      input logic cu, input logic [15:0] u);
    exp_t e;
    @(negedge clk_div_in);
    io_reset = rs;
    enable   = en;
    retrain  = rt;
    s_valid  = sv;
    s_data   = sd;
    e.st = st; e.rst = r; e.data = d; e.link = lk; e.rdy = rdy;
    e.chk_u = cu; e.u = u;
    exp_q.push_back(e);
  endtask

  // RESET, SETTLE and TRAIN observations with enable high; enable drops
  // while TRAIN word drop_at is on the wire (drop_at < 0: never).
  task automatic run_seq(input int drop_at);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, S_RESET, 1'b1, 4'h0, 1'b0, 1'b0, (i == 0), 16'd0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, S_SETTLE, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, (i != drop_at), 1'b0, 1'b0, 4'h0, S_TRAIN, 1'b0, train_word(i),
           1'b0, 1'b0, 1'b0, 16'd0);
      if (i == drop_at) return;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t e;
    logic [3:0] us;
    forever begin
      @(negedge clk_div_in);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("state_o",  32'(state_o),  32'(e.st));
        check("ser_rst",  32'(ser_rst),  32'(e.rst));
        check("ser_data", 32'(ser_data), 32'(e.data));
        check("link_up",  32'(link_up),  32'(e.link));
        check("s_ready",  32'(s_ready),  32'(e.rdy));
        check("sat_outs", 32'({sat_state, sat_rst, sat_data, sat_link, sat_ready}),
              32'({e.st, e.rst, e.data, e.link, e.rdy}));
        if (e.chk_u) begin
          us = (e.u > 16'd15) ? 4'hF : e.u[3:0];
          check("underflow_cnt", 32'(underflow_cnt), 32'(e.u));
          check("underflow_sat", 32'(sat_ucnt), 32'(us));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset held three cycles
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, S_IDLE, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, S_IDLE, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 16'd0);

    // bring-up: enable rise, then 4 + 8 + 16 cycles before RUN
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, S_IDLE, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    run_seq(-1);

    // streaming three words
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'h1, S_RUN, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'h2, S_RUN, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'h3, S_RUN, 1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 16'd0);

    // five underflow cycles (s_data ignored while s_valid is low)
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h7, S_RUN, 1'b0, 4'h3, 1'b1, 1'b1, 1'b1, 16'd0);
    for (int i = 1; i < 5; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'h7, S_RUN, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 16'(i));

    // retrain pulse: s_ready drops in the same cycle, count clears on RESET
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h7, S_RUN, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 16'd5);
    run_seq(7);

    // enable dropped during TRAIN word 7
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, S_IDLE, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, S_IDLE, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, S_IDLE, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    run_seq(-1);

    // retrain together with enable low: IDLE wins, word 5 not taken
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'h5, S_RUN, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, S_IDLE, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, S_IDLE, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    run_seq(-1);

    // retrain alone in RUN: word 6 not taken, full restart
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'h6, S_RUN, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'd0);
    run_seq(-1);

    // twenty underflow cycles: 16-bit count reaches 20, 4-bit sticks at F
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, S_RUN, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 16'(i));
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'h9, S_RUN, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 16'd20);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, S_RUN, 1'b0, 4'h9, 1'b1, 1'b1, 1'b1, 16'd20);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk_div_in);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lvds_ser_ctrl.md
Name: lvds_ser_ctrl

Overview:
Sequencing controller for the 4:1 DDR LVDS output serializer that drives the DAC3162 data/clock lanes.
- Runs in the slow (divided) clock domain.
- Generates the serializer reset, a settle interval and a training-pattern burst, then streams user words with a valid/ready handshake.
- Sits between the DAC sample formatter (upstream) and the serializer's parallel data input and reset (downstream).

Parameters:
DEV_W, 4, parallel word width per clk_div_in cycle (serialization factor × lanes)
RST_CYCLES, 4, cycles ser_rst is held high in RESET (≥1)
SETTLE_CYCLES, 8, cycles of IDLE_PAT after reset release (≥1)
TRAIN_WORDS, 16, training words emitted per training burst (≥1)
TRAIN_PAT, 4'b1010, fixed training word, DEV_W bits
IDLE_PAT, 4'b0000, word driven when not streaming, DEV_W bits
UCNT_W, 16, underflow counter width

Ports:
clk_div_in  input  1  slow serializer clock, sole clock of this block
io_reset  input  1  reset, synchronous, active-high
enable  input  1  level; high starts and keeps the link up
retrain  input  1  one-cycle pulse; forces a new reset/train sequence
s_data  input  DEV_W  user word, bit 0 is first in time on the wire
s_valid  input  1  s_data valid
s_ready  output  1  controller accepts s_data this cycle
ser_data  output  DEV_W  registered word to serializer parallel input
ser_rst  output  1  serializer reset, active-high
link_up  output  1  high while in RUN
underflow_cnt  output  UCNT_W  RUN cycles with s_valid low, saturating
state_o  output  3  current FSM state encoding, for debug

Behaviour:
- Reset (io_reset=1, synchronous) drives: state=IDLE, ser_rst=1, ser_data=IDLE_PAT, s_ready=0, link_up=0, underflow_cnt=0, all internal counters=0.
- FSM states and encodings: IDLE=0, RESET=1, SETTLE=2, TRAIN=3, RUN=4.
  - IDLE: ser_rst=1, ser_data=IDLE_PAT. Goes to RESET when enable=1.
  - RESET: ser_rst=1 for exactly RST_CYCLES cycles, then SETTLE. underflow_cnt clears on entry.
  - SETTLE: ser_rst=0, ser_data=IDLE_PAT for SETTLE_CYCLES cycles, then TRAIN.
  - TRAIN: ser_data=TRAIN_PAT for exactly TRAIN_WORDS cycles, then RUN.
  - RUN: link_up=1, s_ready=1.
    - s_valid=1: ser_data<=s_data.
    - s_valid=0: ser_data<=IDLE_PAT and underflow_cnt increments, saturating at all-ones.
- Handshake: s_ready is combinational from state only: 1 iff state==RUN and enable=1 and retrain=0. A transfer occurs on s_valid&s_ready. The word appears on ser_data one cycle later.
- Priority: io_reset > enable=0 > retrain.
  - enable=0 in any non-IDLE state → IDLE next cycle. ser_rst=1 and ser_data=IDLE_PAT from that cycle.
  - retrain=1 in SETTLE, TRAIN or RUN → RESET next cycle, RST_CYCLES restarts.
  - retrain in IDLE or RESET is ignored.
- Outputs ser_rst, ser_data, link_up and state_o are registered. Total latency from enable rise to first RUN cycle is 1+RST_CYCLES+SETTLE_CYCLES+TRAIN_WORDS cycles.
- Phase counter width is clog2(max(RST_CYCLES, SETTLE_CYCLES, TRAIN_WORDS)+1). It is reloaded on every state entry and never wraps.

Optional Feature:
Macro LVDS_SER_CTRL_PRBS_EN.
- Defined: TRAIN emits PRBS7 words (x^7+x^6+1, seed 7'h7F, DEV_W bits generated per cycle, LSB first) instead of TRAIN_PAT. The LFSR reseeds on every TRAIN entry.
- Undefined: TRAIN emits the constant TRAIN_PAT and no LFSR logic exists.

Decomposition:
- Package lvds_ser_pkg holds:
  - state enum (IDLE..RUN) with its encodings
  - PRBS7 seed and tap constants
  - clog2-based counter-width function
- One natural sub-module: lvds_prbs7_gen, a DEV_W-bits-per-cycle PRBS7 generator with load/advance, instantiated only under the macro.

Test Plan:
1. io_reset 3 cycles then enable=1 → ser_rst high for 4 cycles, IDLE_PAT for 8 cycles, 16×4'b1010, link_up=1 exactly 29 cycles after enable rise.
2. RUN with s_valid=1 and s_data 0x1,0x2,0x3 → ser_data 0x1,0x2,0x3 on the three following cycles. s_ready stays 1.
3. RUN with s_valid low for 5 cycles → ser_data=0x0 those cycles and underflow_cnt=5. A following retrain pulse clears the count on RESET entry.
4. enable dropped mid-TRAIN (word 7) → next cycle state=IDLE, ser_rst=1, ser_data=0x0. Re-enable → full sequence restarts from RESET.
5. retrain and enable=0 in the same RUN cycle → IDLE, not RESET. retrain in RUN alone → ser_rst=1 next cycle for 4 cycles, s_ready=0 in that same cycle.
6. UCNT_W=4 with 20 underflow cycles → underflow_cnt saturates at 4'hF. With LVDS_SER_CTRL_PRBS_EN, the TRAIN words match a reference PRBS7 seeded with 7'h7F.
